// File: rtl/reflet_float_minmax_pkg.sv
// reflet_float_minmax_pkg: shared FPU ordering constants, FSM encoding and NaN detection
package reflet_float_minmax_pkg;

  localparam int FLOAT_SIZE_DEF  = 32;
  localparam int EXP_SIZE_DEF    = 8;
  localparam int COUNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {EMPTY, COLLECT, CMP, OUT} state_t;

  // Key for +0 and -0 alike, MSB-aligned; narrower floats take the top bits.
  localparam logic [63:0] ZERO_KEY = 64'h8000_0000_0000_0000;

  // NaN: exponent all ones and mantissa nonzero, for a float of fs bits with es exponent bits.
  function automatic logic is_nan(input logic [63:0] v, input int fs, input int es);
    logic e_all;
    logic m_any;
    e_all = 1'b1;
    m_any = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i >= fs - 1 - es && i < fs - 1) e_all &= v[i];
      if (i < fs - 1 - es) m_any |= v[i];
    end
    return e_all && m_any;
  endfunction

endpackage

// File: rtl/reflet_float_minmax_if.sv
// reflet_float_minmax_if: sample input stream and result output stream of the min/max reducer
interface reflet_float_minmax_if #(
  parameter int FLOAT_SIZE  = 32,
  parameter int COUNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [FLOAT_SIZE-1:0]  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [FLOAT_SIZE-1:0]  out_min;
  logic [FLOAT_SIZE-1:0]  out_max;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_nan;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count, out_nan
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count, out_nan
  );
endinterface

// File: rtl/reflet_float_order_key.sv
// reflet_float_order_key: maps a signed-magnitude float to an unsigned key with +0 == -0
module reflet_float_order_key
  import reflet_float_minmax_pkg::*;
#(
  parameter int FLOAT_SIZE = 32
) (
  input  logic [FLOAT_SIZE-1:0] val_i,
  output logic [FLOAT_SIZE-1:0] key_o
);
  localparam logic [63:0] ZK = ZERO_KEY >> (64 - FLOAT_SIZE);

  assign key_o = ~|val_i[FLOAT_SIZE-2:0] ? ZK[FLOAT_SIZE-1:0] :
                 val_i[FLOAT_SIZE-1]     ? ~val_i :
                                           {1'b1, val_i[FLOAT_SIZE-2:0]};
endmodule

// File: rtl/reflet_float_minmax.sv
// reflet_float_minmax: streaming packet min/max reducer; REFLET_FLOAT_MINMAX_NAN_EN skips NaN samples
module reflet_float_minmax
  import reflet_float_minmax_pkg::*;
#(
  parameter int FLOAT_SIZE  = FLOAT_SIZE_DEF,
  parameter int EXP_SIZE    = EXP_SIZE_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input logic                 clk,
  input logic                 reset,
  reflet_float_minmax_if.slave bus
);
`ifdef REFLET_FLOAT_MINMAX_NAN_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [FLOAT_SIZE-1:0]  data_q, data_d;
  logic [FLOAT_SIZE-1:0]  min_q, min_d;
  logic [FLOAT_SIZE-1:0]  max_q, max_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   last_q, last_d;
  logic                   first_q, first_d;
  logic                   nan_q, nan_d;
  logic [FLOAT_SIZE-1:0]  key_s, key_min, key_max;
  logic                   accept, skip;

  reflet_float_order_key #(.FLOAT_SIZE(FLOAT_SIZE)) u_key_s   (.val_i(data_q), .key_o(key_s));
  reflet_float_order_key #(.FLOAT_SIZE(FLOAT_SIZE)) u_key_min (.val_i(min_q),  .key_o(key_min));
  reflet_float_order_key #(.FLOAT_SIZE(FLOAT_SIZE)) u_key_max (.val_i(max_q),  .key_o(key_max));

  assign bus.in_ready  = reset && (state_q == EMPTY || state_q == COLLECT);
  assign bus.out_valid = state_q == OUT;
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
  assign bus.out_count = count_q;
  assign bus.out_nan   = nan_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign skip          = NAN_EN && is_nan(64'(data_q), FLOAT_SIZE, EXP_SIZE);

  // Next state and datapath: capture on accept, fold one sample per CMP, clear on result handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    last_d  = last_q;
    first_d = first_q;
    nan_d   = nan_q;
    unique case (state_q)
      EMPTY, COLLECT: if (accept) begin
        data_d  = bus.in_data;
        last_d  = bus.in_last;
        first_d = first_q || state_q == EMPTY;
        state_d = CMP;
      end
      CMP: begin
        state_d = last_q ? OUT : COLLECT;
        if (skip) nan_d = 1'b1;
        else begin
          first_d = 1'b0;
          min_d   = first_q || key_s < key_min ? data_q : min_q;
          max_d   = first_q || key_s > key_max ? data_q : max_q;
          count_d = &count_q ? count_q : count_q + 1'b1;
        end
      end
      OUT: if (bus.out_ready) begin
        min_d   = '0;
        max_d   = '0;
        count_d = '0;
        last_d  = 1'b0;
        first_d = 1'b0;
        nan_d   = 1'b0;
        state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
      last_q  <= last_d;
      first_q <= first_d;
      nan_q   <= nan_d;
    end
  end
endmodule

// File: tb/tb_reflet_float_minmax.sv
// tb_reflet_float_minmax: directed self-checking bench for the min/max reducer
module tb_reflet_float_minmax;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reflet_float_minmax_if #(.FLOAT_SIZE(32), .COUNT_WIDTH(8)) bus ();

  reflet_float_minmax #(.FLOAT_SIZE(32), .EXP_SIZE(8), .COUNT_WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("out_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                               input logic [31:0] cnt, input logic nan);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_min"}, bus.out_min, mn);
    chk({tag, "_max"}, bus.out_max, mx);
    chk({tag, "_count"}, 32'(bus.out_count), cnt);
    chk({tag, "_nan"}, 32'(bus.out_nan), 32'(nan));
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_min", bus.out_min, 32'h0);
    chk("rst_max", bus.out_max, 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_nan", 32'(bus.out_nan), 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    send(32'h3F800000, 1'b0);
    send(32'hC0000000, 1'b0);
    send(32'h40600000, 1'b1);
    wait_out();
    expect_result("mixed", 32'hC0000000, 32'h40600000, 32'd3, 1'b0);

    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40000000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_min", bus.out_min, 32'hC0000000);
      chk("hold_max", bus.out_max, 32'h40600000);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take();
    chk("post_take_valid", 32'(bus.out_valid), 32'd0);
    chk("post_take_ready", 32'(bus.in_ready), 32'd1);
    chk("post_take_count", 32'(bus.out_count), 32'd0);
    chk("post_take_min", bus.out_min, 32'h0);

    send(32'h80000000, 1'b1);
    chk("single_cmp_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    expect_result("single", 32'h80000000, 32'h80000000, 32'd1, 1'b0);
    take();

    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b1);
    wait_out();
    expect_result("zeros", 32'h00000000, 32'h00000000, 32'd2, 1'b0);
    take();

    send(32'h3F800000, 1'b0);
    send(32'h7FC00000, 1'b1);
    wait_out();
`ifdef REFLET_FLOAT_MINMAX_NAN_EN
    expect_result("nan", 32'h3F800000, 32'h3F800000, 32'd1, 1'b1);
`else
    expect_result("nan", 32'h3F800000, 32'h7FC00000, 32'd2, 1'b0);
`endif
    take();

    send(32'hBF800000, 1'b0);
    send(32'hC0000000, 1'b1);
    wait_out();
    expect_result("neg", 32'hC0000000, 32'hBF800000, 32'd2, 1'b0);
    take();

    send(32'h00000000, 1'b0);
    send(32'hFF800000, 1'b0);
    send(32'h7F800000, 1'b1);
    wait_out();
    expect_result("inf", 32'hFF800000, 32'h7F800000, 32'd3, 1'b0);
    take();

    for (int i = 0; i < 299; i++) send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    wait_out();
    expect_result("sat", 32'h3F800000, 32'h3F800000, 32'd255, 1'b0);
    take();

    send(32'h3F800000, 1'b0);
    send(32'hC0000000, 1'b0);
    send(32'h40600000, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_count", 32'(bus.out_count), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_idle_ready", 32'(bus.in_ready), 32'd1);
    send(32'h40000000, 1'b1);
    wait_out();
    expect_result("fresh", 32'h40000000, 32'h40000000, 32'd1, 1'b0);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reflet_float_minmax.md
# reflet_float_minmax

Streaming min/max reducer for the Reflet FPU. It accepts a packet of floating-point samples over a valid/ready stream and computes the packet's smallest and largest values. It uses the same ordering rules as the FPU compare path: signed magnitude, and +0 equals -0. The result is presented on a second valid/ready stream. The block sits after the FPU result bus, or after a memory reader, and is the issuing/consuming end of ordering decisions rather than a single-shot comparator.

## Interface
- float_size, 32, total float width (sign + exponent + mantissa)
- exp_size, 8, exponent width; used only for NaN detection
- count_width, 8, width of the sample counter
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- in_data  in  float_size  sample
- in_last  in  1  marks the final sample of the packet
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_min  out  float_size  smallest sample (raw bits as received)
- out_max  out  float_size  largest sample
- out_count  out  count_width  number of samples reduced, saturating
- out_nan  out  1  at least one NaN was skipped (macro only, else tied 0)

## Operation
- FSM states: EMPTY, COLLECT, CMP, OUT.
- EMPTY: in_ready=1. On accept, register the sample and in_last, set the first flag, and go to CMP.
- CMP: in_ready=0.
  - If the first flag is set, min and max are both loaded with the sample.
  - Otherwise, compare ordering keys: if key < key(min), min is replaced; if key > key(max), max is replaced.
  - On equal keys, the stored value is kept (first occurrence wins; this applies to ±0).
  - out_count increments, saturating at 2^count_width-1.
  - Next state is OUT if last, else COLLECT.
- COLLECT: in_ready=1. On accept, register the sample and go to CMP.
- OUT: out_valid=1 and outputs are stable. On out_ready, clear min, max, count and flags, then go to EMPTY.
- Ordering key is unsigned and float_size wide:
  - magnitude zero gives {1, zeros};
  - positive gives {1, magnitude};
  - negative gives bitwise NOT of the raw value.
- Infinities order naturally through the key. Without the macro, NaNs order by raw key.
- in_data is sampled only on the in_valid && in_ready edge. in_last without valid is ignored.
- Reset values: in_ready=0 during reset, then 1 in EMPTY. out_valid=0, out_min=0, out_max=0, out_count=0, out_nan=0. State is EMPTY.
- Reset mid-packet discards all partial results. No output is produced.

## Timing
- Throughput is one sample per 2 cycles (accept, then CMP).
- Latency: the final sample is accepted at edge t; CMP runs in cycle t+1; out_valid rises after edge t+1.
- out_valid holds with stable data until out_ready. Back-to-back packets: the new packet's first accept happens at the earliest one cycle after the result handshake.
- in_ready is combinational from state only, never from in_valid.

## Configuration
- REFLET_FLOAT_MINMAX_NAN_EN defined:
  - A sample with exponent all ones and mantissa nonzero skips the update in CMP.
  - The sample is not counted and sets out_nan.
  - If the NaN is the last sample, the FSM still goes to OUT.
  - An all-NaN packet gives count 0, min=max=0, out_nan=1.
- Not defined: no NaN check; NaNs are compared by key and counted; out_nan is tied 0.

## Structure
- The shared FPU package holds:
  - the state encoding constants (EMPTY/COLLECT/CMP/OUT);
  - the ±0 canonical key constant;
  - the NaN-detect function parameterised by float_size/exp_size.
- One sub-module, reflet_float_order_key: combinational float-to-unsigned-key mapping, instantiated three times (sample, min, max).

## Test plan
- Packet 3F800000, C0000000, 40600000(last) -> out_min=C0000000, out_max=40600000, out_count=3.
- Single sample 80000000 with last -> min=max=80000000, count=1, out_valid after 2 edges.
- 00000000 then 80000000(last) -> min=max=00000000 (first occurrence kept), count=2.
- Result held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next cycle EMPTY.
- With macro: 3F800000, 7FC00000(last) -> min=max=3F800000, count=1, out_nan=1. Without macro: max=7FC00000, count=2.
- reset=0 asserted during CMP of a 3-sample packet -> next cycle out_valid=0, count=0; a fresh packet 40000000(last) -> min=max=40000000, count=1.
